demux_striping_n: RTL
=====================

DEMUX_STRIPING_N -- requirements
Module: demux_striping_n

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the word width of the input and of each lane.
REQ-002 Parameter NUM_LANES, default 2, sets the lane count; legal range 2..8, non-powers of two included.
REQ-003 Parameter LANE_W, default $clog2(NUM_LANES), sets the lane pointer width.
REQ-004 Port clk_f, input, 1, is the single clock; all state updates on its rising edge.
REQ-005 Port reset_L, input, 1, is the reset: asynchronous, active-low.
REQ-006 Port data_in, input, DATA_WIDTH, carries the incoming word.
REQ-007 Port valid_in, input, 1, qualifies data_in.
REQ-008 Port sop_in, input, 1, is the start-of-packet realign strobe, qualified by valid_in (see Configuration).
REQ-009 Port ready_out, output, 1, is the upstream ready; a transfer occurs when valid_in && ready_out.
REQ-010 Port lane_ready_in, input, NUM_LANES, carries per-lane downstream ready; bit i belongs to lane i.
REQ-011 Port data_out, output, NUM_LANES*DATA_WIDTH, carries lane i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 Port valid_out, output, NUM_LANES, carries per-lane output valid.
REQ-013 Port lane_ptr, output, LANE_W, shows the lane that receives the next accepted word.

Function
REQ-014 Each lane SHALL hold a one-entry output register (data plus valid); data_out and valid_out SHALL be driven directly from these registers.
REQ-015 Target lane T SHALL be lane_ptr, except 0 when sop_in=1 with STRIPE_SYNC_EN defined.
REQ-016 ready_out SHALL be combinational: !valid_out[T] || lane_ready_in[T].
REQ-017 On a transfer, lane T register SHALL load data_in and set its valid on the next edge; latency is exactly 1 cycle.
REQ-018 On a transfer, lane_ptr SHALL advance to T+1, wrapping from NUM_LANES-1 to 0.
REQ-019 Without a transfer, lane_ptr SHALL hold.
REQ-020 Lane i valid SHALL clear when valid_out[i] && lane_ready_in[i] and lane i is not reloaded in the same cycle.
REQ-021 Lane i drained and reloaded in the same cycle: lane i SHALL take the new word with valid kept at 1, giving back-to-back throughput.
REQ-022 lane_ready_in[i] while valid_out[i]=0 SHALL have no effect.
REQ-023 Lane data SHALL hold its value when not loaded, including after valid clears.
REQ-024 valid_in=0 SHALL change no state except draining per REQ-020.
REQ-025 A stalled target lane SHALL block all input even if other lanes are free: strict round-robin order, no lane skipping.

Reset
REQ-026 reset_L=0 SHALL immediately, without a clock, clear all lane data to 0, valid_out to 0 and lane_ptr to 0; ready_out then evaluates to 1.
REQ-027 A transfer or drain in progress at reset assertion SHALL be discarded.
REQ-028 After deassertion, the first accepted word SHALL go to lane 0.

Configuration
REQ-029 Macro STRIPE_SYNC_EN defined: sop_in=1 on a transfer SHALL steer the word to lane 0 and set lane_ptr to 1 (0 when NUM_LANES wraps).
REQ-030 sop_in=1 without a transfer SHALL change nothing.
REQ-031 Macro STRIPE_SYNC_EN undefined: sop_in SHALL be present but ignored, and T SHALL always equal lane_ptr.

Verification
REQ-032 NUM_LANES=3, all lane_ready_in=1, words 0xA0,0xA1,0xA2,0xA3 on consecutive cycles -> lanes 0,1,2,0 receive them one cycle later; lane_ptr sequence 0,1,2,0,1.
REQ-033 NUM_LANES=2, lane_ready_in=2'b00, three valid words -> first two accepted, ready_out=0 on the third; raising lane_ready_in[0] accepts the third into lane 0 on that edge.
REQ-034 Lane 0 full with lane_ready_in[0]=1 and new word 0x55 targeted at lane 0 -> data_out lane 0 = 0x55, valid_out[0] stays 1, no bubble.
REQ-035 STRIPE_SYNC_EN defined, lane_ptr=1, word 0x77 with sop_in=1 -> lane 0 = 0x77, lane_ptr=1; same stimulus with the macro undefined -> lane 1 = 0x77, lane_ptr=0.
REQ-036 reset_L pulsed low mid-clock while valid_out=2'b11 -> outputs zero before the next edge; first post-reset word lands in lane 0.

Source files
------------

// File: rtl/demux_striping_n.sv
// Round-robin striping demux: one input word stream spread over NUM_LANES registered lanes.
// Optional STRIPE_SYNC_EN: sop_in on a transfer realigns the stripe to lane 0.
module demux_striping_n #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 2,
    parameter int LANE_W     = $clog2(NUM_LANES)
) (
    input  logic                            clk_f,
    input  logic                            reset_L,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            valid_in,
    input  logic                            sop_in,
    output logic                            ready_out,
    input  logic [NUM_LANES-1:0]            lane_ready_in,
    output logic [NUM_LANES*DATA_WIDTH-1:0] data_out,
    output logic [NUM_LANES-1:0]            valid_out,
    output logic [LANE_W-1:0]               lane_ptr
);

    generate
        if (NUM_LANES < 2 || NUM_LANES > 8) begin : g_bad_lanes
            $error("demux_striping_n: NUM_LANES must be 2..8");
        end
    endgenerate

    logic [NUM_LANES-1:0]  lane_vld;
    logic [DATA_WIDTH-1:0] lane_dat [NUM_LANES];
    logic [NUM_LANES-1:0]  tgt_sel;
    logic [LANE_W-1:0]     tgt;
    logic [LANE_W-1:0]     ptr_nxt;
    logic                  xfer;

`ifdef STRIPE_SYNC_EN
    assign tgt = sop_in ? '0 : lane_ptr;
`else
    logic sop_unused;
    assign sop_unused = sop_in;
    assign tgt        = lane_ptr;
`endif

    // Only the target lane may accept; a stalled target blocks everything.
    always_comb begin
        tgt_sel   = '0;
        ready_out = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (tgt == LANE_W'(i)) begin
                tgt_sel[i] = 1'b1;
                ready_out  = !lane_vld[i] || lane_ready_in[i];
            end
        end
    end

    assign xfer = valid_in && ready_out;

    always_comb begin
        ptr_nxt = lane_ptr;
        if (xfer) begin
            if (tgt == LANE_W'(NUM_LANES - 1))
                ptr_nxt = '0;
            else
                ptr_nxt = tgt + 1'b1;
        end
    end

    always_ff @(posedge clk_f or negedge reset_L) begin
        if (!reset_L)
            lane_ptr <= '0;
        else
            lane_ptr <= ptr_nxt;
    end

    generate
        for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
            always_ff @(posedge clk_f or negedge reset_L) begin
                if (!reset_L) begin
                    lane_dat[g] <= '0;
                    lane_vld[g] <= 1'b0;
                end else if (xfer && tgt_sel[g]) begin
                    lane_dat[g] <= data_in;
                    lane_vld[g] <= 1'b1;
                end else if (lane_vld[g] && lane_ready_in[g]) begin
                    lane_vld[g] <= 1'b0;
                end
            end

            assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = lane_dat[g];
        end
    endgenerate

    assign valid_out = lane_vld;

endmodule
